// File: rtl/floppy_pkg.sv
// Shared definitions for the floppy sector DMA: command codes, status bits, FSM states.
package floppy_pkg;

    localparam int unsigned BUFF_AW = 9;
    localparam int unsigned LBA_W   = 24;

    localparam logic [7:0] CMD_NONE  = 8'h00;
    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_DONE    = 1;
    localparam int unsigned ST_BADADDR = 2;
    localparam int unsigned ST_MEDIA   = 3;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_CHECK    = 3'd1;
    localparam state_t S_REQ      = 3'd2;
    localparam state_t S_RD_DATA  = 3'd3;
    localparam state_t S_WR_FETCH = 3'd4;
    localparam state_t S_WR_DATA  = 3'd5;
    localparam state_t S_DONE     = 3'd6;
    localparam state_t S_ERR      = 3'd7;

endpackage

// File: rtl/floppy_sector_dma_if.sv
// Media byte-stream and sector-buffer port bundle between the DMA and its neighbours.
interface floppy_sector_dma_if;
    import floppy_pkg::*;

    logic [LBA_W-1:0]   mem_lba;
    logic               mem_rd_req;
    logic               mem_wr_req;
    logic               mem_ack;
    logic [7:0]         mem_rdata;
    logic               mem_rvalid;
    logic [7:0]         mem_wdata;
    logic               mem_wvalid;
    logic               mem_wready;
    logic               mem_err;
    logic               mem_abort;
    logic [BUFF_AW-1:0] buff_addr;
    logic               buff_wr;
    logic [7:0]         buff_odata;
    logic [7:0]         buff_idata;

    modport master (
        output mem_lba, mem_rd_req, mem_wr_req, mem_wdata, mem_wvalid, mem_abort,
               buff_addr, buff_wr, buff_odata,
        input  mem_ack, mem_rdata, mem_rvalid, mem_wready, mem_err, buff_idata
    );

    modport slave (
        input  mem_lba, mem_rd_req, mem_wr_req, mem_wdata, mem_wvalid, mem_abort,
               buff_addr, buff_wr, buff_odata,
        output mem_ack, mem_rdata, mem_rvalid, mem_wready, mem_err, buff_idata
    );

endinterface

// File: rtl/fdd_lba_calc.sv
// Registered track/side/sector to linear block address conversion with sector range check.
module fdd_lba_calc
    import floppy_pkg::*;
#(
    parameter int unsigned SECTORS_PER_TRACK = 9,
    parameter int unsigned SIDES             = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [7:0]       track,
    input  logic [7:0]       sector,
    input  logic             side,
    output logic [LBA_W-1:0] lba,
    output logic             bad
);

    logic [LBA_W-1:0] lba_c;
    logic             bad_c;

    // Sectors are 1-based; the value for sector 0 is meaningless and flagged bad.
    always_comb begin
        lba_c = (LBA_W'(track) * LBA_W'(SIDES) + LBA_W'(side)) * LBA_W'(SECTORS_PER_TRACK)
              + LBA_W'(sector) - LBA_W'(1);
        bad_c = (sector == 8'd0) || (32'(sector) > SECTORS_PER_TRACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lba <= '0;
            bad <= 1'b0;
        end else if (en) begin
            lba <= lba_c;
            bad <= bad_c;
        end
    end

endmodule

// File: rtl/floppy_sector_dma.sv
// Host-side sector mover for the WD1793 core: media stream <-> 512-byte sector buffer.
module floppy_sector_dma
    import floppy_pkg::*;
#(
    parameter int unsigned SECTOR_BYTES      = 512,
    parameter int unsigned SECTORS_PER_TRACK = 9,
    parameter int unsigned SIDES             = 2,
    parameter int unsigned TIMEOUT_CYCLES    = 1 << 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          cpu_command,
    input  logic [7:0]          track,
    input  logic [7:0]          sector,
    input  logic                side,
    output logic [7:0]          cpu_status,
    floppy_sector_dma_if.master bus
);

    localparam int unsigned CNT_W = $clog2(SECTOR_BYTES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state_q, state_d;
    logic [7:0]         cmd_q;
    logic               is_write_q, is_write_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [3:0]         status_q, status_d;
    logic               rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic               abort_q, abort_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               wvalid_q, wvalid_d;
    logic [BUFF_AW-1:0] buff_addr_q, buff_addr_d;
    logic               buff_wr_q, buff_wr_d;
    logic [7:0]         buff_odata_q, buff_odata_d;

    logic               accept_c, busy_c, media_c, beat_c, timeout_c, bad_addr;
    logic [TO_W-1:0]    to_inc_c;

    assign accept_c  = (state_q == S_IDLE) && (cmd_q == CMD_NONE) && (cpu_command != CMD_NONE);
    assign media_c   = (state_q == S_REQ) || (state_q == S_RD_DATA) ||
                       (state_q == S_WR_FETCH) || (state_q == S_WR_DATA);
    assign busy_c    = media_c || (state_q == S_CHECK);
    assign beat_c    = bus.mem_ack || bus.mem_rvalid || bus.mem_wready;
    assign to_inc_c  = to_q + TO_W'(1);
    assign timeout_c = !beat_c && (to_inc_c == TO_W'(TIMEOUT_CYCLES));

    fdd_lba_calc #(
        .SECTORS_PER_TRACK (SECTORS_PER_TRACK),
        .SIDES             (SIDES)
    ) u_lba (
        .clk    (clk),
        .reset  (reset),
        .en     (accept_c),
        .track  (track),
        .sector (sector),
        .side   (side),
        .lba    (bus.mem_lba),
        .bad    (bad_addr)
    );

    // Next-state and next-output logic; withdrawal beats media error beats data beats.
    always_comb begin
        state_d      = state_q;
        is_write_d   = is_write_q;
        count_d      = count_q;
        status_d     = status_q;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        wdata_d      = wdata_q;
        wvalid_d     = wvalid_q;
        buff_addr_d  = buff_addr_q;
        buff_odata_d = buff_odata_q;
        buff_wr_d    = 1'b0;
        abort_d      = 1'b0;
        to_d         = '0;
        if (media_c && !beat_c) begin
            to_d = to_inc_c;
        end

        if (busy_c && (cpu_command == CMD_NONE)) begin
            abort_d  = 1'b1;
            status_d = '0;
            rd_req_d = 1'b0;
            wr_req_d = 1'b0;
            wvalid_d = 1'b0;
            state_d  = S_IDLE;
        end else if (media_c && (bus.mem_err || timeout_c)) begin
            abort_d            = 1'b1;
            status_d           = '0;
            status_d[ST_MEDIA] = 1'b1;
            rd_req_d           = 1'b0;
            wr_req_d           = 1'b0;
            wvalid_d           = 1'b0;
            state_d            = S_ERR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        status_d = '0;
                        if ((cpu_command == CMD_READ) || (cpu_command == CMD_WRITE)) begin
                            status_d[ST_BUSY] = 1'b1;
                            is_write_d        = (cpu_command == CMD_WRITE);
                            state_d           = S_CHECK;
                        end else begin
                            status_d[ST_BADADDR] = 1'b1;
                            state_d              = S_ERR;
                        end
                    end
                end
                S_CHECK: begin
                    if (bad_addr) begin
                        status_d             = '0;
                        status_d[ST_BADADDR] = 1'b1;
                        state_d              = S_ERR;
                    end else begin
                        rd_req_d = !is_write_q;
                        wr_req_d = is_write_q;
                        state_d  = S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.mem_ack) begin
                        rd_req_d    = 1'b0;
                        wr_req_d    = 1'b0;
                        count_d     = '0;
                        buff_addr_d = '0;
                        state_d     = is_write_q ? S_WR_FETCH : S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    // Done waits one cycle so it follows the final buffer write.
                    if (count_q == CNT_W'(SECTOR_BYTES)) begin
                        status_d          = '0;
                        status_d[ST_DONE] = 1'b1;
                        state_d           = S_DONE;
                    end else if (bus.mem_rvalid) begin
                        buff_wr_d    = 1'b1;
                        buff_addr_d  = BUFF_AW'(count_q);
                        buff_odata_d = bus.mem_rdata;
                        count_d      = count_q + CNT_W'(1);
                    end
                end
                S_WR_FETCH: begin
                    buff_addr_d = BUFF_AW'(count_q);
                    state_d     = S_WR_DATA;
                end
                S_WR_DATA: begin
                    // First cycle captures buffer data, then the beat is offered until taken.
                    if (!wvalid_q) begin
                        wdata_d  = bus.buff_idata;
                        wvalid_d = 1'b1;
                    end else if (bus.mem_wready) begin
                        wvalid_d    = 1'b0;
                        count_d     = count_q + CNT_W'(1);
                        buff_addr_d = BUFF_AW'(count_q + CNT_W'(1));
                        if (count_q == CNT_W'(SECTOR_BYTES - 1)) begin
                            status_d          = '0;
                            status_d[ST_DONE] = 1'b1;
                            state_d           = S_DONE;
                        end else begin
                            state_d = S_WR_FETCH;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (cpu_command == CMD_NONE) begin
                        status_d = '0;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_q        <= CMD_NONE;
            is_write_q   <= 1'b0;
            count_q      <= '0;
            to_q         <= '0;
            status_q     <= '0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            abort_q      <= 1'b0;
            wdata_q      <= '0;
            wvalid_q     <= 1'b0;
            buff_addr_q  <= '0;
            buff_wr_q    <= 1'b0;
            buff_odata_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cpu_command;
            is_write_q   <= is_write_d;
            count_q      <= count_d;
            to_q         <= to_d;
            status_q     <= status_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            abort_q      <= abort_d;
            wdata_q      <= wdata_d;
            wvalid_q     <= wvalid_d;
            buff_addr_q  <= buff_addr_d;
            buff_wr_q    <= buff_wr_d;
            buff_odata_q <= buff_odata_d;
        end
    end

    assign cpu_status     = {4'b0000, status_q};
    assign bus.mem_rd_req = rd_req_q;
    assign bus.mem_wr_req = wr_req_q;
    assign bus.mem_abort  = abort_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_wvalid = wvalid_q;
    assign bus.buff_addr  = buff_addr_q;
    assign bus.buff_wr    = buff_wr_q;
    assign bus.buff_odata = buff_odata_q;

endmodule

// File: tb/tb_floppy_sector_dma.sv
// Directed bench for floppy_sector_dma with buffer RAM model and byte scoreboards.
module tb_floppy_sector_dma;

    logic       clk;
    logic       reset;
    logic [7:0] cpu_command;
    logic [7:0] track;
    logic [7:0] sector;
    logic       side;
    logic [7:0] cpu_status;

    floppy_sector_dma_if bus();

    floppy_sector_dma #(
        .SECTOR_BYTES      (512),
        .SECTORS_PER_TRACK (9),
        .SIDES             (2),
        .TIMEOUT_CYCLES    (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_command (cpu_command),
        .track       (track),
        .sector      (sector),
        .side        (side),
        .cpu_status  (cpu_status),
        .bus         (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [16:0] rd_q[$];   // expected {buff_addr, buff_odata}
    logic [7:0]  wr_q[$];   // expected mem_wdata per accepted beat
    int wr_cnt = 0, beat_cnt = 0, abort_cnt = 0, rdreq_cnt = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_wdata = 8'h00;

    logic [7:0] ram [512];
    logic       preload = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_status(input logic [7:0] want, input string tag);
        int n = 0;
        while (cpu_status !== want && n < 100) begin
            cyc();
            n++;
        end
        check(tag, 32'(cpu_status), 32'(want));
    endtask

    // Buffer RAM: registered read, optional preload with i^0x5A.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) ram[i] <= 8'(i) ^ 8'h5A;
        end else if (bus.buff_wr) begin
            ram[bus.buff_addr] <= bus.buff_odata;
        end
        bus.buff_idata <= ram[bus.buff_addr];
    end

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.buff_wr) begin
            wr_cnt++;
            tests++;
            assert (rd_q.size() > 0) else begin
                fails++;
                $error("FAIL rd_unexpected: observed write at 0x%0h expected none", bus.buff_addr);
            end
            if (rd_q.size() > 0) check("rd_byte", {15'd0, bus.buff_addr, bus.buff_odata}, 32'(rd_q.pop_front()));
        end
        if (bus.mem_wvalid && prev_hold) check("wdata_stable", 32'(bus.mem_wdata), 32'(prev_wdata));
        if (bus.mem_wvalid && bus.mem_wready) begin
            beat_cnt++;
            if (wr_q.size() > 0) check("wr_byte", 32'(bus.mem_wdata), 32'(wr_q.pop_front()));
        end
        prev_hold  = bus.mem_wvalid && !bus.mem_wready;
        prev_wdata = bus.mem_wdata;
        if (bus.mem_abort) abort_cnt++;
        if (bus.mem_rd_req) rdreq_cnt++;
    end

    initial begin
        int n, snap_wr, snap_ab, snap_rq, req_cycles;
        logic [7:0] bad_secs [2];
        bad_secs[0] = 8'd0;
        bad_secs[1] = 8'd10;

        reset = 1'b1; cpu_command = 8'h00; track = 8'h00; sector = 8'h00; side = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00; bus.mem_rvalid = 1'b0;
        bus.mem_wready = 1'b0; bus.mem_err = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        check("rst_status", 32'(cpu_status), 32'h00);
        check("rst_lba", 32'(bus.mem_lba), 32'h0);
        check("rst_rdreq", 32'(bus.mem_rd_req), 32'h0);
        check("rst_wvalid", 32'(bus.mem_wvalid), 32'h0);
        check("rst_abort_cnt", 32'(abort_cnt), 32'h0);

        // Read: track 3, side 1, sector 2 -> LBA 64
        track = 8'd3; side = 1'b1; sector = 8'd2; cpu_command = 8'h01;
        cyc();
        check("rd_busy", 32'(cpu_status), 32'h01);
        cyc();
        check("rd_req", 32'(bus.mem_rd_req), 32'h1);
        check("rd_lba", 32'(bus.mem_lba), 32'd64);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        check("rd_req_drop", 32'(bus.mem_rd_req), 32'h0);
        snap_wr = wr_cnt;
        for (int i = 0; i < 512; i++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'(i);
            rd_q.push_back({9'(i), 8'(i)});
            cyc();
            if (i == 0) check("rd_latency", 32'(bus.buff_wr), 32'h1);
        end
        bus.mem_rdata = 8'hEE;
        repeat (3) cyc();
        bus.mem_rvalid = 1'b0;
        wait_status(8'h02, "rd_done");
        check("rd_wr_count", 32'(wr_cnt - snap_wr), 32'd512);
        check("rd_sb_empty", 32'(rd_q.size()), 32'd0);
        cpu_command = 8'h00;
        cyc();
        check("rd_clear", 32'(cpu_status), 32'h00);
        cyc();

        // Write: track 0, side 0, sector 1 -> LBA 0, random wready
        preload = 1'b1; cyc(); preload = 1'b0;
        for (int i = 0; i < 512; i++) wr_q.push_back(8'(i) ^ 8'h5A);
        track = 8'd0; side = 1'b0; sector = 8'd1; cpu_command = 8'h02;
        cyc(); cyc();
        check("wr_req", 32'(bus.mem_wr_req), 32'h1);
        check("wr_lba", 32'(bus.mem_lba), 32'd0);
        bus.mem_ack = 1'b1; cyc(); bus.mem_ack = 1'b0;
        beat_cnt = 0; snap_wr = wr_cnt; n = 0;
        while (beat_cnt < 512 && n < 5000) begin
            bus.mem_wready = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        bus.mem_wready = 1'b0;
        check("wr_beats", 32'(beat_cnt), 32'd512);
        wait_status(8'h02, "wr_done");
        check("wr_sb_empty", 32'(wr_q.size()), 32'd0);
        check("wr_no_bufwr", 32'(wr_cnt - snap_wr), 32'd0);
        cpu_command = 8'h00; cyc(); cyc();

        // Bad sector numbers: no media access
        for (int k = 0; k < 2; k++) begin
            snap_rq = rdreq_cnt; snap_ab = abort_cnt;
            sector = bad_secs[k]; cpu_command = 8'h01;
            cyc(); cyc();
            check("bad_status", 32'(cpu_status), 32'h04);
            repeat (3) cyc();
            check("bad_no_rdreq", 32'(rdreq_cnt - snap_rq), 32'd0);
            check("bad_no_abort", 32'(abort_cnt - snap_ab), 32'd0);
            cpu_command = 8'h00; cyc();
            check("bad_clear", 32'(cpu_status), 32'h00);
            cyc();
        end

        // Unknown command code
        cpu_command = 8'h03; cyc();
        check("unk_status", 32'(cpu_status), 32'h04);
        cpu_command = 8'h00; cyc(); cyc();

        // Media error at read byte 100
        track = 8'd1; side = 1'b0; sector = 8'd1; cpu_command = 8'h01;
        cyc(); cyc();
        bus.mem_ack = 1'b1; cyc(); bus.mem_ack = 1'b0;
        snap_wr = wr_cnt; snap_ab = abort_cnt;
        for (int i = 0; i < 100; i++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'(i + 7);
            rd_q.push_back({9'(i), 8'(i + 7)});
            cyc();
        end
        bus.mem_rdata = 8'hAB; bus.mem_err = 1'b1;
        cyc();
        bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
        check("err_abort", 32'(bus.mem_abort), 32'h1);
        check("err_status", 32'(cpu_status), 32'h08);
        cyc();
        check("err_abort_pulse", 32'(bus.mem_abort), 32'h0);
        check("err_abort_cnt", 32'(abort_cnt - snap_ab), 32'd1);
        check("err_wr_count", 32'(wr_cnt - snap_wr), 32'd100);
        check("err_sb_empty", 32'(rd_q.size()), 32'd0);
        cpu_command = 8'h00; cyc(); cyc();

        // Timeout: ack never arrives
        sector = 8'd1; cpu_command = 8'h01;
        cyc(); cyc();
        n = 0; req_cycles = 0;
        while (bus.mem_abort !== 1'b1 && n < 200) begin
            if (bus.mem_rd_req) req_cycles++;
            cyc();
            n++;
        end
        check("to_abort", 32'(bus.mem_abort), 32'h1);
        check("to_req_cycles", 32'(req_cycles), 32'd64);
        check("to_status", 32'(cpu_status), 32'h08);
        cpu_command = 8'h00; cyc(); cyc();

        // Command withdrawn mid-write, then a fresh read
        preload = 1'b1; cyc(); preload = 1'b0;
        for (int i = 0; i < 512; i++) wr_q.push_back(8'(i) ^ 8'h5A);
        sector = 8'd1; cpu_command = 8'h02;
        cyc(); cyc();
        bus.mem_ack = 1'b1; cyc(); bus.mem_ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.mem_wready = 1'($urandom_range(0, 1));
            cyc();
        end
        snap_ab = abort_cnt;
        bus.mem_wready = 1'b0; cpu_command = 8'h00;
        cyc();
        check("wd_abort", 32'(bus.mem_abort), 32'h1);
        check("wd_status", 32'(cpu_status), 32'h00);
        check("wd_wvalid", 32'(bus.mem_wvalid), 32'h0);
        cyc();
        check("wd_abort_cnt", 32'(abort_cnt - snap_ab), 32'd1);
        wr_q.delete();

        track = 8'd0; side = 1'b1; sector = 8'd9; cpu_command = 8'h01;
        cyc();
        check("re_busy", 32'(cpu_status), 32'h01);
        cyc();
        check("re_req", 32'(bus.mem_rd_req), 32'h1);
        check("re_lba", 32'(bus.mem_lba), 32'd17);
        bus.mem_ack = 1'b1; cyc(); bus.mem_ack = 1'b0;
        for (int i = 0; i < 512; i++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'(i * 3);
            rd_q.push_back({9'(i), 8'(i * 3)});
            cyc();
        end
        bus.mem_rvalid = 1'b0;
        wait_status(8'h02, "re_done");
        check("re_sb_empty", 32'(rd_q.size()), 32'd0);
        cpu_command = 8'h00; cyc();
        check("re_clear", 32'(cpu_status), 32'h00);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
